// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the block UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic IDLE_LEVEL     = 1'b1;
    localparam logic START_LEVEL    = 1'b0;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_block_fifo.sv
// rtl/tx_block_fifo.sv - register-based synchronous block FIFO
// The head entry is read combinationally so it is valid whenever empty is low.
module tx_block_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            wdata,
    output logic [WIDTH-1:0]            rdata,
    output logic                        full,
    output logic                        empty,
    output logic [clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_next(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_block_tx.sv
// rtl/uart_block_tx.sv - queues whole blocks and sends them byte-wise as UART frames
// tx is registered from the next-state decode so the line never glitches.
module uart_block_tx
    import uart_pkg::*;
#(
    parameter int BLOCK_BYTES    = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int CLKS_PER_BIT   = 868,
    parameter int MSB_BYTE_FIRST = 1,
    parameter int PARITY_EN      = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [8*BLOCK_BYTES-1:0]         block_in,
    input  logic                             write_en,
    output logic                             ready,
    output logic                             overflow,
    input  logic                             overflow_clr,
    output logic                             busy,
    output logic [clog2(FIFO_DEPTH+1)-1:0]   blocks_pending,
    output logic                             tx
);

    localparam int BW = 8 * BLOCK_BYTES;
    localparam int CW = clog2(FIFO_DEPTH + 1);
    localparam int IW = (BLOCK_BYTES > 1) ? clog2(BLOCK_BYTES) : 1;
    localparam int TW = clog2(CLKS_PER_BIT);

    uart_tx_state_t state_q, state_d;
    logic [BW-1:0]  blk_q, blk_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [7:0]     byte_q, byte_d;
    logic [2:0]     bit_q, bit_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic           stop_q, stop_d;
    logic           tx_q, tx_d;
    logic           ovf_q;

    logic [BW-1:0]  fifo_rdata;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           pop;
    logic           tick;
    logic           drop;
    int             shamt;
    logic [7:0]     sel_byte;

    tx_block_fifo #(
        .WIDTH (BW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (write_en),
        .pop   (pop),
        .wdata (block_in),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tick  = (tmr_q == TW'(CLKS_PER_BIT - 1));
    assign drop  = write_en && fifo_full;
    assign shamt = (MSB_BYTE_FIRST != 0) ? 8 * (BLOCK_BYTES - 1 - int'(idx_q)) : 8 * int'(idx_q);
    assign sel_byte = 8'(blk_q >> shamt);

    assign ready          = !fifo_full;
    assign overflow       = ovf_q;
    assign busy           = (state_q != IDLE) || !fifo_empty;
    assign blocks_pending = fifo_count;
    assign tx             = tx_q;

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        tmr_d   = tmr_q;
        stop_d  = stop_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (state_q != IDLE && state_q != LOAD) begin
            tmr_d = tick ? '0 : tmr_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                tx_d = IDLE_LEVEL;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    blk_d   = fifo_rdata;
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                byte_d  = sel_byte;
                tmr_d   = '0;
                tx_d    = START_LEVEL;
                state_d = START;
            end
            START: begin
                if (tick) begin
                    bit_d   = '0;
                    tx_d    = byte_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == 3'(UART_DATA_BITS - 1)) begin
                        if (PARITY_EN != 0) begin
                            tx_d    = ^byte_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = IDLE_LEVEL;
                            stop_d  = 1'b0;
                            state_d = STOP;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = byte_q[bit_q + 3'd1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    tx_d    = IDLE_LEVEL;
                    stop_d  = 1'b0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    // stop_q marks that the first of two stop bits has elapsed
                    if (STOP_BITS == 2 && !stop_q) begin
                        stop_d = 1'b1;
                    end else if (idx_q == IW'(BLOCK_BYTES - 1)) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            blk_q   <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            bit_q   <= '0;
            tmr_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= IDLE_LEVEL;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            tmr_q   <= tmr_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (overflow_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_block_tx.sv
// tb/tb_uart_block_tx.sv - self-checking bench for uart_block_tx
// Two instances: A is MSB-first/no parity/1 stop, B is LSB-first/even parity/2 stops.
module tb_uart_block_tx;

    localparam int CPB = 4;
    localparam logic [127:0] FIXED = 128'h00112233445566778899AABBCCDDEEFF;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] block_a = '0, block_b = '0;
    logic         we_a = 1'b0, we_b = 1'b0;
    logic         clr_a = 1'b0, clr_b = 1'b0;
    logic         ready_a, ready_b, ovf_a, ovf_b, busy_a, busy_b, tx_a, tx_b;
    logic [2:0]   pend_a, pend_b;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    logic [7:0] rx_a[$], rx_b[$], exp_a[$], exp_b[$];
    int         rt_a[$], rt_b[$];
    logic       rp_b[$];
    int         fbad_a = 0, fbad_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_block_tx #(.CLKS_PER_BIT(CPB)) dut_a (
        .clk(clk), .reset(reset), .block_in(block_a), .write_en(we_a), .ready(ready_a),
        .overflow(ovf_a), .overflow_clr(clr_a), .busy(busy_a), .blocks_pending(pend_a), .tx(tx_a)
    );

    uart_block_tx #(.CLKS_PER_BIT(CPB), .MSB_BYTE_FIRST(0), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(reset), .block_in(block_b), .write_en(we_b), .ready(ready_b),
        .overflow(ovf_b), .overflow_clr(clr_b), .busy(busy_b), .blocks_pending(pend_b), .tx(tx_b)
    );

    function automatic logic txs(input int sel);
        return (sel != 0) ? tx_b : tx_a;
    endfunction

    function automatic logic busys(input int sel);
        return (sel != 0) ? busy_b : busy_a;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // UART receiver: samples each bit mid-period, abandons a frame on reset
    task automatic rx_run(input int sel, input int npar, input int nstop);
        logic       prev;
        int         t0;
        logic [7:0] d;
        logic       p;
        bit         ab;
        bit         bad;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b1;
            end else if (prev && !txs(sel)) begin
                t0 = cyc; d = '0; p = 1'b0; ab = 1'b0; bad = 1'b0;
                for (int j = 0; j < 9 + npar + nstop && !ab; j++) begin
                    while (cyc < t0 + CPB * j + CPB / 2 && !ab) begin
                        @(negedge clk);
                        if (reset) ab = 1'b1;
                    end
                    if (!ab) begin
                        if (j == 0) bad = bad | (txs(sel) !== 1'b0);
                        else if (j <= 8) d[j-1] = txs(sel);
                        else if (j == 9 && npar != 0) p = txs(sel);
                        else bad = bad | (txs(sel) !== 1'b1);
                    end
                end
                if (!ab) begin
                    if (npar != 0 && p !== ^d) bad = 1'b1;
                    if (sel == 0) begin
                        rx_a.push_back(d); rt_a.push_back(t0);
                        if (bad) fbad_a++;
                    end else begin
                        rx_b.push_back(d); rt_b.push_back(t0); rp_b.push_back(p);
                        if (bad) fbad_b++;
                    end
                end
                prev = 1'b1;
            end else begin
                prev = txs(sel);
            end
        end
    endtask

    initial rx_run(0, 0, 1);
    initial rx_run(1, 1, 2);

    task automatic add_exp(input int sel, input logic [127:0] v, input int nbytes);
        logic [127:0] s;
        s = v;
        for (int k = 0; k < nbytes; k++) begin
            if (sel == 0) begin
                exp_a.push_back(s[127:120]);
                s = s << 8;
            end else begin
                exp_b.push_back(s[7:0]);
                s = s >> 8;
            end
        end
    endtask

    task automatic cmp_stream(input int sel);
        int nmis;
        nmis = 0;
        if (sel == 0) begin
            chk("stream_len_a", 64'(rx_a.size()), 64'(exp_a.size()));
            for (int i = 0; i < rx_a.size() && i < exp_a.size(); i++)
                if (rx_a[i] !== exp_a[i]) nmis++;
            chk("stream_bytes_a", 64'(nmis), 0);
            chk("frame_fmt_a", 64'(fbad_a), 0);
        end else begin
            chk("stream_len_b", 64'(rx_b.size()), 64'(exp_b.size()));
            for (int i = 0; i < rx_b.size() && i < exp_b.size(); i++)
                if (rx_b[i] !== exp_b[i]) nmis++;
            chk("stream_bytes_b", 64'(nmis), 0);
            chk("frame_fmt_b", 64'(fbad_b), 0);
        end
    endtask

    // start-to-start spacing: frame + 1 LOAD cycle, plus 1 IDLE cycle between blocks
    task automatic chk_gaps(input int sel, input int from, input int to, input int flen);
        int nbad, g, e;
        nbad = 0;
        for (int i = from + 1; i <= to; i++) begin
            g = (sel == 0) ? rt_a[i] - rt_a[i-1] : rt_b[i] - rt_b[i-1];
            e = (((i - from) % 16) == 0) ? flen + 2 : flen + 1;
            if (g != e) nbad++;
        end
        chk(sel == 0 ? "gaps_a" : "gaps_b", 64'(nbad), 0);
    endtask

    task automatic wait_idle(input int sel, output int tfall);
        int n;
        n = 0;
        while (busys(sel) !== 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        tfall = cyc;
        chk("idle_wait", 64'(n < 20000), 1);
    endtask

    task automatic wait_rx_a(input int cnt);
        int n;
        n = 0;
        while (rx_a.size() < cnt && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("rx_wait_a", 64'(n < 5000), 1);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : main
        int base, w, tf;
        logic [127:0] v;

        repeat (3) @(negedge clk);
        chk("rst_tx_a", 64'(tx_a), 1);
        chk("rst_ready_a", 64'(ready_a), 1);
        chk("rst_ovf_a", 64'(ovf_a), 0);
        chk("rst_busy_a", 64'(busy_a), 0);
        chk("rst_pend_a", 64'(pend_a), 0);
        chk("rst_tx_b", 64'(tx_b), 1);
        chk("rst_busy_b", 64'(busy_b), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // single fixed block, MSB byte first
        base = rx_a.size();
        block_a = FIXED; we_a = 1'b1; w = cyc;
        @(negedge clk); we_a = 1'b0;
        add_exp(0, FIXED, 16);
        wait_idle(0, tf);
        chk("first_fall_a", 64'(rt_a[base] - w), 3);
        chk_gaps(0, base, base + 15, 10 * CPB);
        chk("busy_fall_a", 64'(tf), 64'(rt_a[base + 15] + 10 * CPB));
        cmp_stream(0);

        // two random blocks back to back
        base = rx_a.size();
        for (int k = 0; k < 2; k++) begin
            v = rnd128(); block_a = v; we_a = 1'b1; add_exp(0, v, 16);
            @(negedge clk);
        end
        we_a = 1'b0;
        wait_idle(0, tf);
        chk_gaps(0, base, base + 31, 10 * CPB);
        cmp_stream(0);

        // LSB first with parity and two stop bits; second block starts with 0x07
        base = rx_b.size();
        block_b = FIXED; we_b = 1'b1; w = cyc; add_exp(1, FIXED, 16);
        @(negedge clk);
        v = {rnd128() >> 8, 8'h07}; block_b = v; add_exp(1, v, 16);
        @(negedge clk); we_b = 1'b0;
        wait_idle(1, tf);
        chk("first_fall_b", 64'(rt_b[base] - w), 3);
        chk("parity_07_b", 64'(rp_b[base + 16]), 1);
        chk("byte_07_b", 64'(rx_b[base + 16]), 64'h07);
        chk_gaps(1, base, base + 31, 12 * CPB);
        chk("busy_fall_b", 64'(tf), 64'(rt_b[base + 31] + 12 * CPB));
        cmp_stream(1);

        // six consecutive writes into a depth-4 queue: the sixth is dropped
        base = rx_a.size();
        for (int k = 0; k < 6; k++) begin
            chk("ready_fill", 64'(ready_a), 64'(k < 5));
            v = rnd128(); block_a = v; we_a = 1'b1;
            if (k < 5) add_exp(0, v, 16);
            @(negedge clk);
        end
        we_a = 1'b0;
        chk("ovf_set", 64'(ovf_a), 1);
        chk("pend_full", 64'(pend_a), 4);
        chk("ready_full", 64'(ready_a), 0);
        wait_rx_a(base + 17);
        chk("pend_dec", 64'(pend_a), 3);
        chk("ovf_sticky", 64'(ovf_a), 1);
        clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
        chk("ovf_clr", 64'(ovf_a), 0);
        wait_idle(0, tf);
        chk("pend_empty", 64'(pend_a), 0);
        cmp_stream(0);

        // dropped write coincident with overflow_clr keeps overflow set
        for (int k = 0; k < 6; k++) begin
            v = rnd128(); block_a = v; we_a = 1'b1; clr_a = (k == 5);
            if (k < 5) add_exp(0, v, 16);
            @(negedge clk);
        end
        we_a = 1'b0; clr_a = 1'b0;
        chk("ovf_set_wins", 64'(ovf_a), 1);
        clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
        chk("ovf_clr2", 64'(ovf_a), 0);
        wait_idle(0, tf);
        cmp_stream(0);

        // reset during byte 3 of a block with two more queued
        base = rx_a.size();
        for (int k = 0; k < 3; k++) begin
            v = rnd128(); block_a = v; we_a = 1'b1;
            if (k == 0) add_exp(0, v, 3);
            @(negedge clk);
        end
        we_a = 1'b0;
        wait_rx_a(base + 3);
        while (cyc < rt_a[base + 2] + 10 * CPB + 1 + 12) @(negedge clk);
        chk("pre_rst_pend", 64'(pend_a), 2);
        chk("pre_rst_busy", 64'(busy_a), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx", 64'(tx_a), 1);
        chk("rst_mid_pend", 64'(pend_a), 0);
        chk("rst_mid_busy", 64'(busy_a), 0);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        chk("no_frames_after_rst", 64'(rx_a.size()), 64'(base + 3));
        chk("line_idle_after_rst", 64'(tx_a), 1);
        cmp_stream(0);

        // a fresh write after reset transmits normally
        base = rx_a.size();
        v = rnd128(); block_a = v; we_a = 1'b1; w = cyc; add_exp(0, v, 16);
        @(negedge clk); we_a = 1'b0;
        wait_idle(0, tf);
        chk("post_rst_fall", 64'(rt_a[base] - w), 3);
        cmp_stream(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
